// File: rtl/ce_gen.sv
// Programmable clock-enable generator: CE strobes every DIV+1 enabled cycles,
// either continuously or as a counted burst that ends with a one-cycle DONE.
module ce_gen #(
  parameter int WIDTH = 16,
  parameter int PW    = 8
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             EN,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic [WIDTH-1:0] DIV,
  input  logic [PW-1:0]    NPULSE,
  output logic             CE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] CNT
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt_n, div_r, div_n;
  logic [PW-1:0]    rem, rem_n;
  logic             mode_r, mode_n;
  logic             ce_n, done_n;
  logic             load;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      CNT    <= '0;
      div_r  <= '0;
      rem    <= '0;
      mode_r <= 1'b0;
      CE     <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_n;
      CNT    <= cnt_n;
      div_r  <= div_n;
      rem    <= rem_n;
      mode_r <= mode_n;
      CE     <= ce_n;
      DONE   <= done_n;
    end
  end

  // STOP dominates everything; a (re)start never issues a CE on its own edge
  always_comb begin
    state_n = state;
    cnt_n   = CNT;
    div_n   = div_r;
    rem_n   = rem;
    mode_n  = mode_r;
    ce_n    = 1'b0;
    done_n  = 1'b0;
    load    = 1'b0;

    case (state)
      IDLE: begin
        if (START && !STOP) load = 1'b1;
      end
      RUN: begin
        if (STOP) begin
          state_n = IDLE;
        end else if (START) begin
          load = 1'b1;
        end else if (EN) begin
          if (CNT != '0) begin
            cnt_n = CNT - WIDTH'(1);
          end else begin
            ce_n  = 1'b1;
            cnt_n = div_r;
            if (mode_r) begin
              if (rem != '0) rem_n = rem - PW'(1);
              if (rem <= PW'(1)) begin
                state_n = FIN;
                done_n  = 1'b1;
              end
            end
          end
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // An empty burst completes immediately without ever running
    if (load) begin
      div_n  = DIV;
      rem_n  = NPULSE;
      mode_n = MODE;
      cnt_n  = DIV;
      if (MODE && (NPULSE == '0)) begin
        state_n = FIN;
        done_n  = 1'b1;
      end else begin
        state_n = RUN;
      end
    end
  end

  assign BUSY = (state == RUN);

endmodule

// File: tb/tb_ce_gen.sv
// Directed bench for ce_gen: the driver queues hand-computed per-edge
// expectations, and an independent monitor pops and checks them each cycle.
module tb_ce_gen;

  typedef struct {
    logic        ce;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr, en, start, stop, mode;
  logic [15:0] div;
  logic [7:0]  npulse;
  logic        ce, busy, done;
  logic [15:0] cnt;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ce_gen #(.WIDTH(16), .PW(8)) dut (
    .C(clk), .CLR(clr), .EN(en), .START(start), .STOP(stop), .MODE(mode),
    .DIV(div), .NPULSE(npulse), .CE(ce), .BUSY(busy), .DONE(done), .CNT(cnt)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs, then queue what the outputs must be after it
  task automatic apply_stimulus(input logic c, e, sa, so, m,
                                input logic [15:0] d, input logic [7:0] np,
                                input logic x_ce, x_busy, x_done,
                                input logic [15:0] x_cnt);
    exp_t x;
    @(negedge clk);
    clr = c; en = e; start = sa; stop = so; mode = m; div = d; npulse = np;
    @(posedge clk);
    #1;
    x.ce = x_ce; x.busy = x_busy; x.done = x_done; x.cnt = x_cnt;
    exp_q.push_back(x);
  endtask

  task automatic check_output(input string name, input logic x_ce, x_busy, x_done,
                              input logic [15:0] x_cnt);
    total++;
    if (ce !== x_ce || busy !== x_busy || done !== x_done || cnt !== x_cnt) begin
      bad++;
      $display("[TB] FAIL %s: got ce=%b busy=%b done=%b cnt=%0d, want ce=%b busy=%b done=%b cnt=%0d",
               name, ce, busy, done, cnt, x_ce, x_busy, x_done, x_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check_output("edge", x.ce, x.busy, x.done, x.cnt);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clr = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    div = '0; npulse = '0;
    #2;
    check_output("async_reset", 1'b0, 1'b0, 1'b0, 16'd0);

    apply_stimulus(1, 1, 1, 0, 0, 16'd5, 8'd2, 0, 0, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd5, 8'd2, 0, 0, 0, 16'd0);

    // Continuous, DIV=3: CE after edges 4 and 8; DIV changes mid-run are ignored
    apply_stimulus(0, 1, 1, 0, 0, 16'd3, 8'd0, 0, 1, 0, 16'd3);
    apply_stimulus(0, 1, 0, 0, 0, 16'd3, 8'd0, 0, 1, 0, 16'd2);
    apply_stimulus(0, 1, 0, 0, 0, 16'd3, 8'd0, 0, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd3, 8'd0, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd7, 8'd0, 1, 1, 0, 16'd3);
    apply_stimulus(0, 1, 0, 0, 1, 16'd7, 8'd0, 0, 1, 0, 16'd2);
    apply_stimulus(0, 1, 0, 0, 1, 16'd7, 8'd0, 0, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd7, 8'd0, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd7, 8'd0, 1, 1, 0, 16'd3);
    apply_stimulus(0, 1, 0, 1, 0, 16'd7, 8'd0, 0, 0, 0, 16'd3);

    // Continuous, DIV=2 with EN low for five edges stretches the period by five
    apply_stimulus(0, 1, 1, 0, 0, 16'd2, 8'd0, 0, 1, 0, 16'd2);
    apply_stimulus(0, 1, 0, 0, 0, 16'd2, 8'd0, 0, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd2, 8'd0, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd2, 8'd0, 1, 1, 0, 16'd2);
    apply_stimulus(0, 1, 0, 0, 0, 16'd2, 8'd0, 0, 1, 0, 16'd1);
    for (int i = 0; i < 5; i++)
      apply_stimulus(0, 0, 0, 0, 0, 16'd2, 8'd0, 0, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd2, 8'd0, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd2, 8'd0, 1, 1, 0, 16'd2);
    apply_stimulus(0, 1, 0, 1, 0, 16'd2, 8'd0, 0, 0, 0, 16'd2);

    // Burst of three with DIV=1; START while in FIN is ignored
    apply_stimulus(0, 1, 1, 0, 1, 16'd1, 8'd3, 0, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd9, 8'd9, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd9, 8'd9, 1, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd9, 8'd9, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd9, 8'd9, 1, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd9, 8'd9, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd9, 8'd9, 1, 0, 1, 16'd1);
    apply_stimulus(0, 1, 1, 0, 0, 16'd5, 8'd0, 0, 0, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd5, 8'd0, 0, 0, 0, 16'd1);

    // Empty burst: DONE right after START, no CE, never busy
    apply_stimulus(0, 1, 1, 0, 1, 16'd4, 8'd0, 0, 0, 1, 16'd4);
    apply_stimulus(0, 1, 0, 0, 1, 16'd4, 8'd0, 0, 0, 0, 16'd4);

    // START and STOP together on the terminal-count edge: STOP wins, no CE
    apply_stimulus(0, 1, 1, 0, 0, 16'd1, 8'd0, 0, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd1, 8'd0, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 1, 1, 0, 16'd1, 8'd0, 0, 0, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd1, 8'd0, 0, 0, 0, 16'd0);

    // Restart in RUN re-latches DIV and reloads without a CE
    apply_stimulus(0, 1, 1, 0, 0, 16'd3, 8'd0, 0, 1, 0, 16'd3);
    apply_stimulus(0, 1, 0, 0, 0, 16'd3, 8'd0, 0, 1, 0, 16'd2);
    apply_stimulus(0, 1, 1, 0, 0, 16'd1, 8'd0, 0, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 0, 0, 16'd1, 8'd0, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd1, 8'd0, 1, 1, 0, 16'd1);
    apply_stimulus(0, 1, 0, 1, 0, 16'd1, 8'd0, 0, 0, 0, 16'd1);

    // DIV=0 strobes every cycle; CLR mid-cycle drops CE/BUSY before the next edge
    apply_stimulus(0, 1, 1, 0, 0, 16'd0, 8'd0, 0, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd0, 8'd0, 1, 1, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd0, 8'd0, 1, 1, 0, 16'd0);
    @(negedge clk);
    #2 clr = 1'b1;
    #1 check_output("clr_midrun", 1'b0, 1'b0, 1'b0, 16'd0);
    apply_stimulus(1, 1, 0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 16'd0);
    apply_stimulus(0, 1, 0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 16'd0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ce_gen.md
CE_GEN -- requirements
Module: ce_gen

Interface
REQ-001 Parameter WIDTH, default 16, width of the divide counter and DIV input.
REQ-002 Parameter PW, default 8, width of the burst pulse-count input NPULSE.
REQ-003 C  input  1  clock; all state updates on posedge C.
REQ-004 CLR  input  1  reset, asynchronous, active-high.
REQ-005 EN  input  1  count enable; low freezes the divider.
REQ-006 START  input  1  synchronous start/restart strobe.
REQ-007 STOP  input  1  synchronous abort strobe.
REQ-008 MODE  input  1  0 = continuous, 1 = burst.
REQ-009 DIV  input  WIDTH  divide value; CE period is DIV+1 enabled cycles.
REQ-010 NPULSE  input  PW  number of CE pulses in burst mode.
REQ-011 CE  output  1  registered single-cycle clock-enable strobe for downstream FDCE-style registers.
REQ-012 BUSY  output  1  high while in RUN.
REQ-013 DONE  output  1  registered one-cycle strobe at burst completion.
REQ-014 CNT  output  WIDTH  current divider count value.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-016 IDLE: CE=0 and BUSY=0; START=1 (with STOP=0) SHALL latch DIV into div_r, NPULSE into rem and MODE into mode_r, load CNT=DIV, and go to RUN.
REQ-017 RUN with EN=1: CNT!=0 SHALL decrement CNT with CE<=0; CNT==0 SHALL set CE<=1 and reload CNT=div_r.
REQ-018 RUN with EN=0: CNT, rem and state SHALL hold, and CE<=0.
REQ-019 First CE SHALL be high in the cycle following the (DIV+1)th enabled edge after the START edge; subsequent CEs SHALL occur every div_r+1 enabled cycles.
REQ-020 DIV=0 SHALL produce CE high on every enabled cycle in RUN.
REQ-021 Divide values SHALL be unsigned, and the counter SHALL never wrap below 0.
REQ-022 Changes on DIV, NPULSE or MODE while in RUN SHALL have no effect until the next START.
REQ-023 Burst mode: each CE issued SHALL decrement rem; the CE issued with rem==1 SHALL move the state to FIN on the same edge.
REQ-024 Burst mode with NPULSE=0 SHALL go from IDLE directly to FIN on START, issuing no CE.
REQ-025 FIN: DONE=1 and BUSY=0 for exactly one cycle, then IDLE unconditionally; DONE SHALL be 0 in every other state.
REQ-026 Continuous mode SHALL never enter FIN and SHALL run until STOP or CLR.
REQ-027 STOP=1 in any state SHALL force IDLE with CE<=0 and DONE<=0 on that edge, and SHALL suppress a terminal-count CE due that edge.
REQ-028 START and STOP both high on the same edge: STOP SHALL win.
REQ-029 START=1 in RUN SHALL restart: re-latch DIV, NPULSE and MODE, reload CNT, and issue no CE on that edge.
REQ-030 START=1 in FIN SHALL be ignored.
REQ-031 CE and DONE SHALL be driven directly from flops with no combinational path from inputs.

Reset
REQ-032 CLR=1 SHALL immediately, without a clock, force state=IDLE, CE=0, BUSY=0, DONE=0, CNT=0, rem=0, div_r=0 and mode_r=0.
REQ-033 Global GSR (glbl.GSR) asserted SHALL have the same effect as CLR.
REQ-034 CLR asserted mid-RUN SHALL abort with no further CE until a new START after CLR deasserts.
REQ-035 The first edge with CLR low SHALL be a normal IDLE evaluation.

Verification
REQ-036 MODE=0, DIV=3, EN=1, START pulse at edge 0 -> CE high after edges 4, 8, 12 ...; BUSY=1 from edge 0.
REQ-037 MODE=1, DIV=1, NPULSE=3 -> exactly 3 CE pulses spaced 2 cycles apart, DONE high for one cycle coincident with the cycle after the third CE edge, then BUSY=0.
REQ-038 MODE=0, DIV=2, EN low for 5 cycles mid-count -> CNT frozen, CE period stretched by exactly 5 cycles.
REQ-039 STOP and START together on the edge where CNT==0 -> no CE, state IDLE, BUSY=0.
REQ-040 MODE=1, NPULSE=0, START -> DONE one cycle later, no CE.
REQ-041 CLR asserted asynchronously between edges during RUN with DIV=0 -> CE and BUSY drop before the next edge; no CE after CLR deasserts until START.
